// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Assembles a serial bit stream into WIDTH-bit words and presents each word
//   through a one-entry valid/ready holding register. A completed word that
//   finds the holding register full and not being consumed is dropped, and
//   the sticky overrun flag is set.
//
//   Optional feature macro: SIPO_PARITY_EN
//     defined   : each word is WIDTH data bits followed by one even-parity bit;
//                 parity_err is loaded alongside par_out.
//     undefined : words are WIDTH bits; parity_err is tied to 0.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   clear       synchronous flush of partial word, bit counter and overrun
//   ser_in      serial data bit
//   ser_valid   ser_in is sampled on this edge
//   par_out     assembled word (holding register)
//   par_valid   par_out holds an unconsumed word
//   par_ready   downstream takes par_out on this edge when par_valid=1
//   bit_cnt     bits accepted into the current partial word
//   overrun     sticky: a completed word was dropped
//   parity_err  parity flag for the word in the holding register

module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       ser_in,
    input  logic                       ser_valid,
    output logic [WIDTH-1:0]           par_out,
    output logic                       par_valid,
    input  logic                       par_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun,
    output logic                       parity_err
);

    localparam int CNT_W = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_EN
    localparam int LAST = WIDTH;        // parity bit closes the word
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] word_data;
    logic             word_perr;
    logic             accept;
    logic             word_done;
    logic             shift_en;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_next = {shift_reg[WIDTH-2:0], ser_in};
        end else begin : g_lsb
            assign shift_next = {ser_in, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    // clear wins over a simultaneous bit, so that bit never counts
    assign accept    = ser_valid && !clear;
    assign word_done = accept && (bit_cnt == LAST_CNT);

`ifdef SIPO_PARITY_EN
    // The parity bit is not shifted in: data is already complete in shift_reg.
    assign shift_en  = accept && !word_done;
    assign word_data = shift_reg;
    assign word_perr = (^shift_reg) ^ ser_in;
`else
    assign shift_en  = accept;
    assign word_data = shift_next;
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            if (shift_en)
                shift_reg <= shift_next;
            if (word_done)
                bit_cnt <= '0;
            else if (accept)
                bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    logic perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out   <= '0;
            par_valid <= 1'b0;
            perr_q    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (word_done) begin
                if (!par_valid || par_ready) begin
                    par_out   <= word_data;
                    perr_q    <= word_perr;
                    par_valid <= 1'b1;
                end
            end else if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end

            if (clear)
                overrun <= 1'b0;
            else if (word_done && par_valid && !par_ready)
                overrun <= 1'b1;
        end
    end

`ifdef SIPO_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: two instances (MSB-first and LSB-first) share
// the same stimulus. A table of per-cycle vectors drives the default build;
// hand sequences cover reset state, mid-word reset and the parity build.

module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       par_ready = 1'b0;
    logic [3:0] m_out, l_out;
    logic       m_valid, l_valid;
    logic [2:0] m_cnt, l_cnt;
    logic       m_ovr, l_ovr;
    logic       m_perr, l_perr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
        .par_out(m_out), .par_valid(m_valid), .par_ready(par_ready),
        .bit_cnt(m_cnt), .overrun(m_ovr), .parity_err(m_perr));

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
        .par_out(l_out), .par_valid(l_valid), .par_ready(par_ready),
        .bit_cnt(l_cnt), .overrun(l_ovr), .parity_err(l_perr));

    typedef struct {
        logic       clr;
        logic       din;
        logic       vld;
        logic       rdy;
        logic [3:0] e_msb;
        logic [3:0] e_lsb;
        logic       e_valid;
        logic [2:0] e_cnt;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic d, input logic v, input logic r);
        clear = c; ser_in = d; ser_valid = v; par_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic d, input logic v, input logic r,
                                input logic [3:0] em, input logic [3:0] el,
                                input logic ev, input logic [2:0] ec, input logic eo);
        vec_t t;
        t.clr = c; t.din = d; t.vld = v; t.rdy = r;
        t.e_msb = em; t.e_lsb = el; t.e_valid = ev; t.e_cnt = ec; t.e_ovr = eo;
        return t;
    endfunction

    initial begin
        // reset state
        #2;
        chk("rst_par_out", 0, 16'(m_out), 16'h0);
        chk("rst_par_valid", 0, 16'(m_valid), 16'h0);
        chk("rst_bit_cnt", 0, 16'(m_cnt), 16'h0);
        chk("rst_overrun", 0, 16'(m_ovr), 16'h0);
        chk("rst_parity_err", 0, 16'(m_perr), 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef SIPO_PARITY_EN
        // bits 1,0,1,1 with ready: MSB 1011, LSB 1101, valid for one cycle
        vecs.push_back(mk(0,1,1,1, 4'h0,4'h0, 0,1,0));
        vecs.push_back(mk(0,0,1,1, 4'h0,4'h0, 0,2,0));
        vecs.push_back(mk(0,1,1,1, 4'h0,4'h0, 0,3,0));
        vecs.push_back(mk(0,1,1,1, 4'b1011,4'b1101, 1,0,0));
        vecs.push_back(mk(0,0,0,1, 4'b1011,4'b1101, 0,0,0));
        vecs.push_back(mk(0,0,0,1, 4'b1011,4'b1101, 0,0,0));
        // not ready: 1010 then 0110, second word dropped
        vecs.push_back(mk(0,1,1,0, 4'b1011,4'b1101, 0,1,0));
        vecs.push_back(mk(0,0,1,0, 4'b1011,4'b1101, 0,2,0));
        vecs.push_back(mk(0,1,1,0, 4'b1011,4'b1101, 0,3,0));
        vecs.push_back(mk(0,0,1,0, 4'b1010,4'b0101, 1,0,0));
        vecs.push_back(mk(0,0,1,0, 4'b1010,4'b0101, 1,1,0));
        vecs.push_back(mk(0,1,1,0, 4'b1010,4'b0101, 1,2,0));
        vecs.push_back(mk(0,1,1,0, 4'b1010,4'b0101, 1,3,0));
        vecs.push_back(mk(0,0,1,0, 4'b1010,4'b0101, 1,0,1));
        vecs.push_back(mk(0,0,0,1, 4'b1010,4'b0101, 0,0,1));
        vecs.push_back(mk(1,0,0,0, 4'b1010,4'b0101, 0,0,0));
        // 1100 then 0011, ready only on the completing edge of 0011
        vecs.push_back(mk(0,1,1,0, 4'b1010,4'b0101, 0,1,0));
        vecs.push_back(mk(0,1,1,0, 4'b1010,4'b0101, 0,2,0));
        vecs.push_back(mk(0,0,1,0, 4'b1010,4'b0101, 0,3,0));
        vecs.push_back(mk(0,0,1,0, 4'b1100,4'b0011, 1,0,0));
        vecs.push_back(mk(0,0,1,0, 4'b1100,4'b0011, 1,1,0));
        vecs.push_back(mk(0,0,1,0, 4'b1100,4'b0011, 1,2,0));
        vecs.push_back(mk(0,1,1,0, 4'b1100,4'b0011, 1,3,0));
        vecs.push_back(mk(0,1,1,1, 4'b0011,4'b1100, 1,0,0));
        vecs.push_back(mk(0,0,0,1, 4'b0011,4'b1100, 0,0,0));
        // clear beats a simultaneous bit; following word is clean
        vecs.push_back(mk(0,1,1,1, 4'b0011,4'b1100, 0,1,0));
        vecs.push_back(mk(0,1,1,1, 4'b0011,4'b1100, 0,2,0));
        vecs.push_back(mk(1,1,1,1, 4'b0011,4'b1100, 0,0,0));
        vecs.push_back(mk(0,0,1,1, 4'b0011,4'b1100, 0,1,0));
        vecs.push_back(mk(0,1,1,1, 4'b0011,4'b1100, 0,2,0));
        vecs.push_back(mk(0,1,1,1, 4'b0011,4'b1100, 0,3,0));
        vecs.push_back(mk(0,1,1,1, 4'b0111,4'b1110, 1,0,0));
        vecs.push_back(mk(0,0,0,1, 4'b0111,4'b1110, 0,0,0));
        // ser_valid gaps hold the partial word
        vecs.push_back(mk(0,1,1,0, 4'b0111,4'b1110, 0,1,0));
        vecs.push_back(mk(0,0,0,0, 4'b0111,4'b1110, 0,1,0));
        vecs.push_back(mk(0,1,1,0, 4'b0111,4'b1110, 0,2,0));
        vecs.push_back(mk(0,0,0,0, 4'b0111,4'b1110, 0,2,0));
        vecs.push_back(mk(0,0,1,0, 4'b0111,4'b1110, 0,3,0));
        vecs.push_back(mk(0,0,1,0, 4'b1100,4'b0011, 1,0,0));
        vecs.push_back(mk(0,0,0,0, 4'b1100,4'b0011, 1,0,0));
        vecs.push_back(mk(0,0,0,1, 4'b1100,4'b0011, 0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].din, vecs[i].vld, vecs[i].rdy);
            chk("msb_par_out", i, 16'(m_out), 16'(vecs[i].e_msb));
            chk("lsb_par_out", i, 16'(l_out), 16'(vecs[i].e_lsb));
            chk("par_valid", i, 16'(m_valid), 16'(vecs[i].e_valid));
            chk("bit_cnt", i, 16'(m_cnt), 16'(vecs[i].e_cnt));
            chk("overrun", i, 16'(m_ovr), 16'(vecs[i].e_ovr));
            chk("parity_err", i, 16'(m_perr), 16'h0);
        end

        // mid-word asynchronous reset, then a clean word
        drive(0,1,1,1);
        drive(0,1,1,1);
        chk("pre_rst_cnt", 0, 16'(m_cnt), 16'h2);
        ser_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_cnt", 0, 16'(m_cnt), 16'h0);
        chk("async_rst_out", 0, 16'(m_out), 16'h0);
        chk("async_rst_valid", 0, 16'(m_valid), 16'h0);
        #1 rst = 1'b0;
        drive(0,0,1,1);
        drive(0,1,1,1);
        drive(0,0,1,1);
        drive(0,1,1,1);
        chk("post_rst_msb", 0, 16'(m_out), 16'b0101);
        chk("post_rst_lsb", 0, 16'(l_out), 16'b1010);
        chk("post_rst_valid", 0, 16'(m_valid), 16'h1);
        chk("post_rst_cnt", 0, 16'(m_cnt), 16'h0);
`else
        // data 1011 + parity 1 (even, consistent)
        drive(0,1,1,1);
        drive(0,0,1,1);
        drive(0,1,1,1);
        drive(0,1,1,1);
        chk("par_cnt_at_width", 0, 16'(m_cnt), 16'h4);
        chk("par_valid_before_pbit", 0, 16'(m_valid), 16'h0);
        drive(0,1,1,1);
        chk("par_msb_out", 0, 16'(m_out), 16'b1011);
        chk("par_lsb_out", 0, 16'(l_out), 16'b1101);
        chk("par_valid", 0, 16'(m_valid), 16'h1);
        chk("par_err_ok", 0, 16'(m_perr), 16'h0);
        chk("par_cnt_wrap", 0, 16'(m_cnt), 16'h0);
        // data 1011 + parity 0 (wrong)
        drive(0,1,1,1);
        drive(0,0,1,1);
        drive(0,1,1,1);
        drive(0,1,1,1);
        drive(0,0,1,1);
        chk("par_msb_out2", 1, 16'(m_out), 16'b1011);
        chk("par_err_bad", 1, 16'(m_perr), 16'h1);
        chk("par_err_bad_lsb", 1, 16'(l_perr), 16'h1);
        chk("par_valid2", 1, 16'(m_valid), 16'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
